// File: rtl/mmio_ctrl_pkg.sv
// Shared constants for the memory-mapped IO controller: register window, offsets,
// seven-segment glyphs and the address decoder.
package mmio_ctrl_pkg;

  localparam logic [31:0] IO_BASE    = 32'hFFFF_FC00;
  localparam logic [31:0] IO_LED_OFF = 32'h0000_0000;
  localparam logic [31:0] IO_SW_OFF  = 32'h0000_0004;
  localparam logic [31:0] IO_SEG_OFF = 32'h0000_0008;
  localparam logic [31:0] IO_BTN_OFF = 32'h0000_000C;
  localparam logic [31:0] IO_TMR_OFF = 32'h0000_0010;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [15:0][7:0] SEG_GLYPHS = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic [2:0] {
    REG_LED,
    REG_SW,
    REG_SEG,
    REG_BTN,
    REG_TMR,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
    logic [29:0] word_idx;
    word_idx = addr[31:2] - base[31:2];
    case (word_idx)
      IO_LED_OFF[31:2]: decode_addr = REG_LED;
      IO_SW_OFF[31:2]:  decode_addr = REG_SW;
      IO_SEG_OFF[31:2]: decode_addr = REG_SEG;
      IO_BTN_OFF[31:2]: decode_addr = REG_BTN;
      IO_TMR_OFF[31:2]: decode_addr = REG_TMR;
      default:          decode_addr = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_ctrl_if.sv
// IO-side bus between the memory-access stage (master) and the IO controller (slave).
interface mmio_ctrl_if;

  logic [31:0] io_addr;
  logic [31:0] io_write_data;
  logic        io_we;
  logic [31:0] io_read_data;

  modport master (
    output io_addr,
    output io_write_data,
    output io_we,
    input  io_read_data
  );

  modport slave (
    input  io_addr,
    input  io_write_data,
    input  io_we,
    output io_read_data
  );

endinterface

// File: rtl/mmio_ctrl_debouncer.sv
// Two-flop synchroniser followed by a vector debouncer: the input must hold one value
// for DEBOUNCE_CYCLES cycles before it replaces the stable output.
module debouncer #(
  parameter int unsigned WIDTH           = 1,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [19:0]      cnt_q, cnt_d;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so each flop samples the pre-edge value of the others.
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_out = stable_q;

endmodule

// File: rtl/mmio_ctrl_seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner; anode and cathode are both registered
// from the same digit index so they always switch together.
module seg7_scan
  import mmio_ctrl_pkg::*;
#(
  parameter logic [16:0] SCAN_DIV = 17'd100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  logic [16:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  an_q, an_d;
  logic [7:0]  cat_q, cat_d;

  always_comb begin
    cnt_d = cnt_q + 17'd1;
    idx_d = idx_q;
    if (cnt_q == SCAN_DIV - 17'd1) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    an_d  = ~(8'b1 << idx_q);
    cat_d = SEG_GLYPHS[value[{idx_q, 2'b00} +: 4]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= SEG_OFF;
      cat_q <= SEG_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      cat_q <= cat_d;
    end
  end

  assign seg_an  = an_q;
  assign seg_cat = cat_q;

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped IO controller: LED, debounced switch, button-flag, seven-segment and
// millisecond-timer registers behind a zero-latency combinational read port.
module mmio_ctrl #(
  parameter logic [31:0] IO_BASE         = mmio_ctrl_pkg::IO_BASE,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [16:0] SCAN_DIV        = 17'd100_000,
  parameter logic [16:0] TICK_DIV        = 17'd100_000
) (
  input  logic          clk,
  input  logic          rst,
  mmio_ctrl_if.slave    bus,
  input  logic [23:0]   sw_in,
  input  logic          btn_in,
  output logic [23:0]   led_out,
  output logic [7:0]    seg_an,
  output logic [7:0]    seg_cat
);

  import mmio_ctrl_pkg::*;

  logic [23:0] led_q, led_d;
  logic [31:0] seg_val_q, seg_val_d;
  logic        pending_q, pending_d;
  logic        btn_prev_q, btn_prev_d;
  logic [31:0] timer_q, timer_d;
  logic [16:0] presc_q, presc_d;

  logic [23:0] sw_db;
  logic        btn_db;
  logic        btn_rise;
  reg_sel_e    sel;
  logic        unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bus.io_addr[1:0]};
  assign sel              = decode_addr(bus.io_addr, IO_BASE);
  assign btn_rise         = btn_db & ~btn_prev_q;

  debouncer #(.WIDTH(24), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (sw_in),
    .stable_out (sw_db)
  );

  debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (btn_in),
    .stable_out (btn_db)
  );

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .value   (seg_val_q),
    .seg_an  (seg_an),
    .seg_cat (seg_cat)
  );

  always_comb begin
    led_d      = led_q;
    seg_val_d  = seg_val_q;
    pending_d  = pending_q;
    btn_prev_d = btn_db;
    timer_d    = timer_q;
    presc_d    = presc_q + 17'd1;
    if (presc_q == TICK_DIV - 17'd1) begin
      presc_d = '0;
      timer_d = timer_q + 32'd1;
    end
    // Bus writes are applied after the tick so a same-cycle timer write wins.
    if (bus.io_we) begin
      case (sel)
        REG_LED: led_d     = bus.io_write_data[23:0];
        REG_SEG: seg_val_d = bus.io_write_data;
        REG_BTN: if (bus.io_write_data[0]) pending_d = 1'b0;
        REG_TMR: begin
          timer_d = bus.io_write_data;
          presc_d = '0;
        end
        default: ;
      endcase
    end
    // A press edge overrides a clear landing in the same cycle.
    if (btn_rise) pending_d = 1'b1;
  end

  always_comb begin
    bus.io_read_data = '0;
    case (sel)
      REG_LED: bus.io_read_data = {8'h0, led_q};
      REG_SW:  bus.io_read_data = {8'h0, sw_db};
      REG_SEG: bus.io_read_data = seg_val_q;
      REG_BTN: bus.io_read_data = {31'h0, pending_q};
      REG_TMR: bus.io_read_data = timer_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      seg_val_q  <= '0;
      pending_q  <= 1'b0;
      btn_prev_q <= 1'b0;
      timer_q    <= '0;
      presc_q    <= '0;
    end else begin
      led_q      <= led_d;
      seg_val_q  <= seg_val_d;
      pending_q  <= pending_d;
      btn_prev_q <= btn_prev_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: register reads go through an expected-value queue,
// peripheral outputs are compared against the bench's own glyph table and timing model.
module tb_mmio_ctrl;

  localparam logic [31:0] BASE  = 32'hFFFF_FC00;
  localparam logic [31:0] A_LED = BASE + 32'h00;
  localparam logic [31:0] A_SW  = BASE + 32'h04;
  localparam logic [31:0] A_SEG = BASE + 32'h08;
  localparam logic [31:0] A_BTN = BASE + 32'h0C;
  localparam logic [31:0] A_TMR = BASE + 32'h10;
  localparam logic [31:0] A_BAD = BASE + 32'h20;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sw_in;
  logic        btn_in;
  logic [23:0] led_out;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mmio_ctrl_if bus();

  mmio_ctrl #(
    .DEBOUNCE_CYCLES (20'd4),
    .SCAN_DIV        (17'd2),
    .TICK_DIV        (17'd3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sw_in   (sw_in),
    .btn_in  (btn_in),
    .led_out (led_out),
    .seg_an  (seg_an),
    .seg_cat (seg_cat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_read();
    exp_t e;
    e = sb_q.pop_front();
    check(e.tag, bus.io_read_data, e.exp);
  endtask

  task automatic expect_read(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    bus.io_addr = addr;
    sb_q.push_back('{tag, exp});
    #1;
    compare_read();
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    bus.io_addr       = addr;
    bus.io_write_data = data;
    bus.io_we         = 1'b1;
    cyc();
    bus.io_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  prev_an;
    logic [7:0]  seen;
    logic [7:0]  exp_cat;
    logic [31:0] seg_val;
    int          run;
    bit          run_started;
    int          idx;

    rst               = 1'b1;
    bus.io_addr       = '0;
    bus.io_write_data = '0;
    bus.io_we         = 1'b0;
    sw_in             = '0;
    btn_in            = 1'b0;
    repeat (3) cyc();
    check("rst_led", {8'h0, led_out}, 32'h0);
    check("rst_an", {24'h0, seg_an}, 32'hFF);
    check("rst_cat", {24'h0, seg_cat}, 32'hFF);
    rst = 1'b0;
    cyc();

    // LED: same-cycle read returns the old value, new value visible afterwards.
    bus.io_addr       = A_LED;
    bus.io_write_data = 32'h00AB_CDEF;
    bus.io_we         = 1'b1;
    #1;
    check("led_same_cycle", bus.io_read_data, 32'h0);
    cyc();
    bus.io_we = 1'b0;
    check("led_out", {8'h0, led_out}, 32'h00AB_CDEF);
    expect_read(A_LED, "led_rd", 32'h00AB_CDEF);
    write(A_LED, 32'hFF12_3456);
    check("led_out_mask", {8'h0, led_out}, 32'h0012_3456);
    expect_read(A_LED, "led_rd_mask", 32'h0012_3456);

    // Switches: a 2-cycle 0x55 glitch must never be reported.
    sw_in = 24'h000055;
    cyc();
    cyc();
    sw_in = 24'h0000AA;
    for (int i = 0; i < 4; i++) begin
      cyc();
      expect_read(A_SW, "sw_early", 32'h0);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      bus.io_addr = A_SW;
      #1;
      if (bus.io_read_data != 32'h0) break;
    end
    expect_read(A_SW, "sw_settle", 32'h0000_00AA);
    write(A_SW, 32'h0000_0123);
    expect_read(A_SW, "sw_write_ignored", 32'h0000_00AA);

    // Button flag.
    btn_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      bus.io_addr = A_BTN;
      #1;
      if (bus.io_read_data[0]) break;
    end
    expect_read(A_BTN, "btn_set", 32'h1);
    write(A_BTN, 32'h0);
    expect_read(A_BTN, "btn_wr0_keep", 32'h1);
    write(A_BTN, 32'h1);
    expect_read(A_BTN, "btn_clear", 32'h0);
    btn_in = 1'b0;
    repeat (12) cyc();
    expect_read(A_BTN, "btn_release", 32'h0);
    // Hold a clear write every cycle while pressing: only set-wins lets the flag appear.
    bus.io_addr       = A_BTN;
    bus.io_write_data = 32'h1;
    bus.io_we         = 1'b1;
    btn_in            = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.io_read_data[0]) break;
    end
    bus.io_we = 1'b0;
    cyc();
    expect_read(A_BTN, "btn_set_wins", 32'h1);

    // Seven-segment scan.
    seg_val = 32'h7654_3210;
    write(A_SEG, seg_val);
    expect_read(A_SEG, "seg_rd", seg_val);
    cyc();
    cyc();
    prev_an     = seg_an;
    seen        = '0;
    run         = 0;
    run_started = 1'b0;
    for (int s = 0; s < 20; s++) begin
      if (s > 0) begin
        cyc();
        if (seg_an != prev_an) begin
          check("seg_an_step", {24'h0, seg_an}, {24'h0, prev_an[6:0], prev_an[7]});
          if (run_started) check("seg_an_dwell", run, 2);
          run_started = 1'b1;
          run         = 0;
        end
      end
      run++;
      prev_an = seg_an;
      idx     = -1;
      for (int d = 0; d < 8; d++) if (seg_an == ~(8'b1 << d)) idx = d;
      exp_cat = 8'hxx;
      if (idx >= 0) begin
        exp_cat   = glyph[seg_val[idx*4 +: 4]];
        seen[idx] = 1'b1;
      end
      check("seg_cat", {24'h0, seg_cat}, {24'h0, exp_cat});
    end
    check("seg_all_digits", {24'h0, seen}, 32'hFF);

    // Timer wrap and tick/write collision.
    write(A_TMR, 32'hFFFF_FFFE);
    expect_read(A_TMR, "tmr_load", 32'hFFFF_FFFE);
    cyc();
    cyc();
    expect_read(A_TMR, "tmr_hold", 32'hFFFF_FFFE);
    cyc();
    expect_read(A_TMR, "tmr_inc", 32'hFFFF_FFFF);
    repeat (3) cyc();
    expect_read(A_TMR, "tmr_wrap", 32'h0);
    cyc();
    cyc();
    write(A_TMR, 32'h1234_0000);
    expect_read(A_TMR, "tmr_tick_write", 32'h1234_0000);
    cyc();
    cyc();
    expect_read(A_TMR, "tmr_presc_zeroed", 32'h1234_0000);
    cyc();
    expect_read(A_TMR, "tmr_after_write", 32'h1234_0001);

    // Reset mid-operation.
    rst = 1'b1;
    cyc();
    check("rst2_led", {8'h0, led_out}, 32'h0);
    check("rst2_an", {24'h0, seg_an}, 32'hFF);
    check("rst2_cat", {24'h0, seg_cat}, 32'hFF);
    expect_read(A_LED, "rst2_led_rd", 32'h0);
    expect_read(A_SEG, "rst2_seg_rd", 32'h0);
    expect_read(A_BTN, "rst2_btn_rd", 32'h0);
    expect_read(A_TMR, "rst2_tmr_rd", 32'h0);
    expect_read(A_SW, "rst2_sw_rd", 32'h0);
    rst    = 1'b0;
    btn_in = 1'b0;
    cyc();
    write(A_BAD, 32'hDEAD_BEEF);
    expect_read(A_BAD, "unmapped_rd", 32'h0);
    expect_read(A_LED, "unmapped_no_alias_led", 32'h0);
    expect_read(A_SEG, "unmapped_no_alias_seg", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
